pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Hazard and stall sequencer for the 6-stage pipeline (IF, ID, RR, EX, MEM, WB).
- Detects load-use hazards between the load in EX (RR_EX) and its consumer in RR (ID_RR), and inserts bubbles.
- Flushes IF_ID on a decoded jump.
- Freezes the whole pipeline while data memory signals busy.
- Drives per-stage write enables, the bubble/flush controls and PC write enable. Sits beside the existing forwarding unit, which already covers ALU-to-ALU dependencies.

Parameters:
- REG_AW, 5, register address width.
- LU_CYCLES, 1, total bubbles per load-use hazard. Legal range 1–3.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- ex_memread  in  1  memread bit of the instruction in EX (RR_EX).
- ex_rt  in  REG_AW  destination (rt) of the instruction in EX.
- rr_rs  in  REG_AW  rs of the instruction in RR (ID_RR).
- rr_rt  in  REG_AW  rt of the instruction in RR.
- rr_uses_rt  in  1  RR instruction reads rt as a source (0 for immediate/load forms).
- id_jump  in  1  PCSrc from the control unit, for the instruction in ID.
- mem_busy  in  1  data memory not ready; hold all stages.
- pc_we  out  1  PC update enable.
- if_id_we  out  1  IF_ID load enable.
- id_rr_we  out  1  ID_RR load enable.
- rr_ex_bubble  out  1  load all-zero control into RR_EX (NOP).
- if_id_flush  out  1  load 32'h0 into IF_ID.
- ex_mem_we  out  1  EX_MEM load enable.
- mem_wb_we  out  1  MEM_WB load enable.
- state  out  2  current FSM state: RUN=0, LU_STALL=1, FREEZE=2.
- stall_cnt  out  CNT_W  load-use bubbles inserted (only when the optional feature is compiled in).
- flush_cnt  out  CNT_W  jump flushes performed (only when the optional feature is compiled in).

Behaviour:
- Reset (rst=1 at posedge clk):
  - state=RUN, remaining-bubble counter rem=0, perf counters 0.
  - While rst is high, all *_we=0 and rr_ex_bubble=0, if_id_flush=0.
  - Reset mid-stall or mid-freeze aborts it; the first cycle after reset is RUN.
- Hazard condition (combinational): haz = ex_memread & (ex_rt!=0) & ((ex_rt==rr_rs) | (rr_uses_rt & ex_rt==rr_rt)). Register 0 never causes a stall.
- Outputs are a combinational decode of state, rem and the inputs. State and rem update at posedge clk.
- Priority: rst > mem_busy > load-use stall > jump flush.
- RUN state:
  - mem_busy=1: all *_we=0, rr_ex_bubble=0, if_id_flush=0; next state FREEZE with rem unchanged; return state RUN is saved.
  - else haz=1: pc_we=if_id_we=id_rr_we=0, rr_ex_bubble=1, ex_mem_we=mem_wb_we=1. This cycle is bubble 1. If LU_CYCLES>1, next state LU_STALL with rem=LU_CYCLES-1; otherwise stay in RUN.
  - else id_jump=1: all enables 1, if_id_flush=1 (overrides the IF_ID load). PC loads the jump target this edge.
  - else: all enables 1, bubble=0, flush=0.
- LU_STALL state:
  - Same outputs as a RUN-state stall, held regardless of haz/id_jump. The EX contents are now a bubble, so haz is ignored.
  - rem decrements each cycle; when rem reaches 0, next state RUN.
  - mem_busy=1 moves to FREEZE with rem preserved and return state LU_STALL saved.
- FREEZE state:
  - All *_we=0, bubble=0, flush=0.
  - Remains while mem_busy=1; on mem_busy=0, returns to the saved state. rem is not decremented while frozen.
- Simultaneous jump and hazard: the stall wins and id_jump is ignored. IF_ID holds, so the jump re-presents in ID after the stall and is flushed then.
- With the optional feature compiled in:
  - stall_cnt increments on every cycle with rr_ex_bubble=1 and rst=0.
  - flush_cnt increments on every cycle with if_id_flush=1 and rst=0.
  - Both saturate at all-ones; no wrap.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: stall_cnt and flush_cnt ports and saturating counters exist as specified.
- Undefined: both ports and all counter logic are absent; all other behaviour is identical.

Test Plan:
- Load-use on rs: ex_memread=1, ex_rt=5, rr_rs=5, LU_CYCLES=1 -> one cycle of pc_we=if_id_we=id_rr_we=0, rr_ex_bubble=1; next cycle (ex_memread=0) all enables 1.
- r0 and rt-not-used: ex_rt=0=rr_rs -> no stall. ex_rt=7=rr_rt with rr_uses_rt=0 -> no stall.
- LU_CYCLES=3 with mem_busy pulsed for 2 cycles during bubble 2 -> exactly 3 bubble cycles total; FREEZE lasts 2 cycles; stall_cnt=3.
- id_jump=1 alone -> if_id_flush=1, pc_we=1 for one cycle; flush_cnt=1. id_jump with haz -> stall first, flush one cycle after the stall ends.
- rst asserted in LU_STALL with rem=1 -> the cycle after rst drops, state=RUN, counters 0, all enables 1.
- flush_cnt preloaded near all-ones (CNT_W=16) -> after further flushes it holds at 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / jump / memory-busy hazard sequencer for the 6-stage pipeline.
// Optional saturating perf counters (stall_cnt, flush_cnt) under `HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned LU_CYCLES = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] rr_rs,
    input  logic [REG_AW-1:0] rr_rt,
    input  logic              rr_uses_rt,
    input  logic              id_jump,
    input  logic              mem_busy,
    output logic              pc_we,
    output logic              if_id_we,
    output logic              id_rr_we,
    output logic              rr_ex_bubble,
    output logic              if_id_flush,
    output logic              ex_mem_we,
    output logic              mem_wb_we,
    output logic [1:0]        state
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    localparam int unsigned REM_W = 2;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FREEZE   = 2'd2
    } state_t;

    if (LU_CYCLES < 1 || LU_CYCLES > 3 || CNT_W < 1) begin : g_bad_param
        $error("pipeline_hazard_ctrl: LU_CYCLES must be 1..3 and CNT_W >= 1");
    end

    state_t            state_q, state_d;
    state_t            ret_q, ret_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic              haz;

    // Register 0 is hardwired zero, so a load into it never creates a dependency.
    assign haz = ex_memread && (ex_rt != '0) &&
                 ((ex_rt == rr_rs) || (rr_uses_rt && (ex_rt == rr_rt)));

    assign state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            ret_q   <= RUN;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        rem_d        = rem_q;
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_rr_we     = 1'b0;
        rr_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        ex_mem_we    = 1'b0;
        mem_wb_we    = 1'b0;

        unique case (state_q)
            RUN: begin
                if (mem_busy) begin
                    state_d = FREEZE;
                    ret_d   = RUN;
                end else if (haz) begin
                    rr_ex_bubble = 1'b1;
                    ex_mem_we    = 1'b1;
                    mem_wb_we    = 1'b1;
                    if (LU_CYCLES > 1) begin
                        state_d = LU_STALL;
                        rem_d   = REM_W'(LU_CYCLES - 1);
                    end
                end else begin
                    pc_we       = 1'b1;
                    if_id_we    = 1'b1;
                    id_rr_we    = 1'b1;
                    ex_mem_we   = 1'b1;
                    mem_wb_we   = 1'b1;
                    if_id_flush = id_jump;
                end
            end
            LU_STALL: begin
                if (mem_busy) begin
                    state_d = FREEZE;
                    ret_d   = LU_STALL;
                end else begin
                    // EX already holds a bubble here, so haz and id_jump are ignored.
                    rr_ex_bubble = 1'b1;
                    ex_mem_we    = 1'b1;
                    mem_wb_we    = 1'b1;
                    rem_d        = rem_q - REM_W'(1);
                    if (rem_q <= REM_W'(1)) begin
                        state_d = RUN;
                    end
                end
            end
            FREEZE: begin
                if (!mem_busy) begin
                    state_d = ret_q;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (rst) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_rr_we     = 1'b0;
            rr_ex_bubble = 1'b0;
            if_id_flush  = 1'b0;
            ex_mem_we    = 1'b0;
            mem_wb_we    = 1'b0;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    // Saturating event counters; bubble/flush are already forced low during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (rr_ex_bubble && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (if_id_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`else
    // Counters not built in this configuration.
`endif

endmodule
